// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Types and constants shared by the triangle-fetch slice.
//   coord_t   : one 9-bit vertex coordinate
//   vertex_t  : three coordinates, index [2:0]
//   state_t   : fetch FSM states
//   tag_t     : in-flight read tag (valid + vertex slot 0..2)
// A 27-bit memory word packs one vertex: [26:18]=vert[2], [17:9]=vert[1],
// [8:0]=vert[0].
// -----------------------------------------------------------------------------
package gfx_pkg;

   localparam int COORD_W   = 9;
   localparam int WORD_W    = 3 * COORD_W;
   localparam int VERT0_LSB = 0;
   localparam int VERT1_LSB = 9;
   localparam int VERT2_LSB = 18;

   typedef logic [COORD_W-1:0] coord_t;
   typedef coord_t             vertex_t [2:0];

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      COLLECT,
      PRESENT,
      DONE
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] slot;
   } tag_t;

   // Extract coordinate idx (0..2) from a packed vertex word.
   function automatic coord_t word_field(input logic [WORD_W-1:0] word, input int idx);
      coord_t field;
      case (idx)
         0:       field = word[VERT0_LSB +: COORD_W];
         1:       field = word[VERT1_LSB +: COORD_W];
         default: field = word[VERT2_LSB +: COORD_W];
      endcase
      return field;
   endfunction

endpackage

// File: rtl/tri_fetch_if.sv
// -----------------------------------------------------------------------------
// tri_fetch_if
// Bundles the vertex-memory read port and the triangle handshake toward the
// rasterizer.
//   mem_addr   fetcher -> memory   vertex word address
//   mem_data   memory  -> fetcher  packed vertex, MEM_LATENCY cycles later
//   vert1..3   fetcher -> raster   triangle vertices
//   valid_tri  fetcher -> raster   vertices hold a triangle
//   obj_done   fetcher -> raster   presented triangle is the last of the object
//   ready_in   raster  -> fetcher  rasterizer can accept a triangle
// modport master: the fetcher; modport slave: memory + rasterizer side.
// -----------------------------------------------------------------------------
interface tri_fetch_if
   import gfx_pkg::*;
#(
   parameter int ADDR_W = 10
);

   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_data;
   vertex_t           vert1;
   vertex_t           vert2;
   vertex_t           vert3;
   logic              valid_tri;
   logic              obj_done;
   logic              ready_in;

   modport master (
      output mem_addr, vert1, vert2, vert3, valid_tri, obj_done,
      input  mem_data, ready_in
   );

   modport slave (
      input  mem_addr, vert1, vert2, vert3, valid_tri, obj_done,
      output mem_data, ready_in
   );

endinterface

// File: rtl/tri_fetch_tagpipe.sv
// -----------------------------------------------------------------------------
// tri_fetch_tagpipe
// DEPTH-stage shift line that follows each memory read through the memory
// latency, so the fetcher knows which vertex slot the current mem_data
// belongs to. A tag entering in cycle c leaves in cycle c+DEPTH.
//   clk_in  clock          rst_in  synchronous active-high reset
//   flush   drop every in-flight tag (frame abort)
//   head    tag for the address presented this cycle
//   tail    tag matching mem_data this cycle
// DEPTH must be at least 1.
// -----------------------------------------------------------------------------
module tri_fetch_tagpipe
   import gfx_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic flush,
   input  tag_t head,
   output tag_t tail
);

   tag_t stage [DEPTH];

   // NOTE: sequential state is written with <= only, so every stage samples
   // the value its neighbour held before this edge.
   always_ff @(posedge clk_in) begin
      if (rst_in || flush) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= head;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tail = stage[DEPTH-1];

endmodule

// File: rtl/tri_fetch.sv
// -----------------------------------------------------------------------------
// tri_fetch
// Fetches triangles (three consecutive 27-bit vertex words at 3t..3t+2) from a
// fixed-latency vertex memory and presents them one at a time to a rasterizer
// through a valid/ready handshake.
//   clk_in     clock, rising edge
//   rst_in     synchronous active-high reset
//   new_frame  one-cycle pulse: start (or abort and restart) at triangle 0
//   num_tris   triangle count, sampled with new_frame, clamped to MAX_TRIS
//   bus        tri_fetch_if.master: memory read port + triangle handshake
// A new_frame while a frame is in progress aborts it: in-flight reads are
// discarded and fetching restarts with the newly sampled count.
// -----------------------------------------------------------------------------
module tri_fetch
   import gfx_pkg::*;
#(
   parameter int MAX_TRIS    = 256,
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = $clog2(3 * MAX_TRIS)
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          new_frame,
   input  logic [$clog2(MAX_TRIS+1)-1:0] num_tris,
   tri_fetch_if.master                   bus
);

   localparam int               CNT_W   = $clog2(MAX_TRIS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIS);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        slot;
   logic [CNT_W-1:0]  tri_idx;
   logic [CNT_W-1:0]  tri_count;
   logic              valid;
   logic              done;
   vertex_t           vert1;
   vertex_t           vert2;
   vertex_t           vert3;

   logic [CNT_W-1:0]  frame_count;
   logic              handshake;
   logic              last;
   tag_t              head;
   tag_t              tail;

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      frame_count = num_tris;
      if (num_tris > MAX_CNT) frame_count = MAX_CNT;
      head       = '0;
      head.valid = (state == ISSUE);
      head.slot  = slot;
   end

   assign handshake = valid && bus.ready_in;
   assign last      = (tri_idx == tri_count - CNT_W'(1));

   // new_frame is a no-op flush from IDLE/DONE (nothing in flight) and an
   // abort from any busy state, so it can drive the flush unconditionally.
   tri_fetch_tagpipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tagpipe (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .flush  (new_frame),
      .head   (head),
      .tail   (tail)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= IDLE;
         addr      <= '0;
         slot      <= '0;
         tri_idx   <= '0;
         tri_count <= '0;
         valid     <= 1'b0;
         done      <= 1'b0;
         // NOTE: the vertex registers are cleared on reset because they are
         // visible outputs; they are flops, not a RAM, so this is cheap.
         for (int i = 0; i < 3; i++) begin
            vert1[i] <= '0;
            vert2[i] <= '0;
            vert3[i] <= '0;
         end
      end else if (new_frame) begin
         // Start from IDLE/DONE or abort a frame in progress; a handshake in
         // this same cycle has already completed on the rasterizer side.
         valid     <= 1'b0;
         tri_idx   <= '0;
         slot      <= '0;
         tri_count <= frame_count;
         if (frame_count == '0) begin
            state <= DONE;
            done  <= 1'b1;          // empty object: single pulse, no reads
         end else begin
            state <= ISSUE;
            addr  <= '0;
            done  <= 1'b0;
         end
      end else begin
         if (tail.valid) begin
            for (int i = 0; i < 3; i++) begin
               case (tail.slot)
                  2'd0:    vert1[i] <= word_field(bus.mem_data, i);
                  2'd1:    vert2[i] <= word_field(bus.mem_data, i);
                  default: vert3[i] <= word_field(bus.mem_data, i);
               endcase
            end
         end

         case (state)
            IDLE: ;
            ISSUE: begin
               if (slot == 2'd2) begin
                  state <= COLLECT;
               end else begin
                  addr <= addr + ADDR_W'(1);
                  slot <= slot + 2'd1;
               end
            end
            COLLECT: begin
               if (tail.valid && tail.slot == 2'd2) begin
                  state <= PRESENT;
                  valid <= 1'b1;
                  done  <= last;
               end
            end
            PRESENT: begin
               if (handshake) begin
                  valid <= 1'b0;
                  done  <= 1'b0;
                  if (last) begin
                     state <= DONE;
                  end else begin
                     state   <= ISSUE;
                     tri_idx <= tri_idx + CNT_W'(1);
                     addr    <= addr + ADDR_W'(1);   // 3t+2 -> 3(t+1)
                     slot    <= '0;
                  end
               end
            end
            DONE:    done  <= 1'b0;                 // ends the empty-object pulse
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr  = addr;
   assign bus.valid_tri = valid;
   assign bus.obj_done  = done;
   assign bus.vert1     = vert1;
   assign bus.vert2     = vert2;
   assign bus.vert3     = vert3;

endmodule
